dds_sweep_gen: RTL and testbench

- Stepped-frequency (chirp) phase-increment generator. It sits directly upstream of the Taylor-series DDS and drives that block's din/din_valid/din_ready port.
- Each frequency level is a signed phase increment. The block holds each level for a programmable number of accepted samples, then steps by a signed delta.
- Supports single-shot, sawtooth-repeat and triangle sweeps.
- Configuration is latched on a start pulse so software can rewrite the config inputs mid-sweep without effect.

---
 rtl/dds_sweep_gen.sv | 167 ++++++++++++++++
 tb/tb_dds_sweep_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_gen
// Description : Stepped-frequency (chirp) phase-increment generator that
//               feeds the Taylor-series DDS. Supports single, sawtooth and
//               triangle sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_gen #(
    parameter int G_DOUT_WIDTH = 24,
    parameter int G_CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [G_DOUT_WIDTH-1:0] f_start,
    input  logic [G_DOUT_WIDTH-1:0] f_step,
    input  logic [G_CNT_WIDTH-1:0]  num_steps,
    input  logic [G_CNT_WIDTH-1:0]  dwell,
    output logic [G_DOUT_WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    busy,
    output logic                    done
);

    localparam logic       c_ST_IDLE  = 1'b0;
    localparam logic       c_ST_RUN   = 1'b1;
    localparam logic [1:0] c_MODE_SAW = 2'd1;
    localparam logic [1:0] c_MODE_TRI = 2'd2;
    localparam logic       c_DIR_UP   = 1'b0;
    localparam logic       c_DIR_DN   = 1'b1;
    localparam logic [G_CNT_WIDTH-1:0] c_CNT_ZERO = '0;
    localparam logic [G_CNT_WIDTH-1:0] c_CNT_ONE  = {{(G_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                    r_state;
    logic [1:0]              r_mode;
    logic [G_DOUT_WIDTH-1:0] r_f_start;
    logic [G_DOUT_WIDTH-1:0] r_f_step;
    logic [G_CNT_WIDTH-1:0]  r_last_idx;
    logic [G_CNT_WIDTH-1:0]  r_dwell_last;
    logic [G_CNT_WIDTH-1:0]  r_idx;
    logic [G_CNT_WIDTH-1:0]  r_dc;
    logic                    r_dir;
    logic [G_DOUT_WIDTH-1:0] r_freq;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_xfer;
    logic                    w_level_end;
    logic                    w_leg_end;
    logic [G_DOUT_WIDTH-1:0] w_freq_up;
    logic [G_DOUT_WIDTH-1:0] w_freq_dn;
    logic [G_CNT_WIDTH-1:0]  w_last_idx_in;
    logic [G_CNT_WIDTH-1:0]  w_dwell_last_in;

    // Zero counts behave as one, so the terminal values saturate at zero.
    assign w_last_idx_in   = (num_steps == c_CNT_ZERO) ? c_CNT_ZERO : num_steps - c_CNT_ONE;
    assign w_dwell_last_in = (dwell == c_CNT_ZERO) ? c_CNT_ZERO : dwell - c_CNT_ONE;

    assign w_xfer      = r_valid & dout_ready;
    assign w_level_end = (r_dc == r_dwell_last);
    assign w_leg_end   = (r_dir == c_DIR_UP) ? (r_idx == r_last_idx) : (r_idx == c_CNT_ZERO);
    assign w_freq_up   = r_freq + r_f_step;
    assign w_freq_dn   = r_freq - r_f_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_mode       <= 2'd0;
            r_f_start    <= '0;
            r_f_step     <= '0;
            r_last_idx   <= '0;
            r_dwell_last <= '0;
            r_idx        <= '0;
            r_dc         <= '0;
            r_dir        <= c_DIR_UP;
            r_freq       <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (!enable) begin
            r_state      <= c_ST_IDLE;
            r_mode       <= 2'd0;
            r_f_start    <= '0;
            r_f_step     <= '0;
            r_last_idx   <= '0;
            r_dwell_last <= '0;
            r_idx        <= '0;
            r_dc         <= '0;
            r_dir        <= c_DIR_UP;
            r_freq       <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_mode       <= mode;
                        r_f_start    <= f_start;
                        r_f_step     <= f_step;
                        r_last_idx   <= w_last_idx_in;
                        r_dwell_last <= w_dwell_last_in;
                        r_freq       <= f_start;
                        r_idx        <= '0;
                        r_dc         <= '0;
                        r_dir        <= c_DIR_UP;
                        r_valid      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= c_ST_RUN;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        if (!w_level_end) begin
                            r_dc <= r_dc + c_CNT_ONE;
                        end else begin
                            r_dc <= '0;
                            if (!w_leg_end) begin
                                if (r_dir == c_DIR_UP) begin
                                    r_freq <= w_freq_up;
                                    r_idx  <= r_idx + c_CNT_ONE;
                                end else begin
                                    r_freq <= w_freq_dn;
                                    r_idx  <= r_idx - c_CNT_ONE;
                                end
                            end else if (r_mode == c_MODE_SAW) begin
                                r_freq <= r_f_start;
                                r_idx  <= '0;
                            end else if (r_mode == c_MODE_TRI) begin
                                // A one-level leg has nowhere to turn to; hold f_start.
                                if (r_last_idx != c_CNT_ZERO) begin
                                    if (r_dir == c_DIR_UP) begin
                                        r_dir  <= c_DIR_DN;
                                        r_freq <= w_freq_dn;
                                        r_idx  <= r_idx - c_CNT_ONE;
                                    end else begin
                                        r_dir  <= c_DIR_UP;
                                        r_freq <= w_freq_up;
                                        r_idx  <= r_idx + c_CNT_ONE;
                                    end
                                end
                            end else begin
                                r_state <= c_ST_IDLE;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign dout       = r_freq;
    assign dout_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_sweep_gen
// Description : Directed self-checking bench for dds_sweep_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_gen;

    localparam int c_W = 24;
    localparam int c_C = 16;

    logic           clk;
    logic           reset_n;
    logic           enable;
    logic           start;
    logic [1:0]     mode;
    logic [c_W-1:0] f_start;
    logic [c_W-1:0] f_step;
    logic [c_C-1:0] num_steps;
    logic [c_C-1:0] dwell;
    logic [c_W-1:0] dout;
    logic           dout_valid;
    logic           dout_ready;
    logic           busy;
    logic           done;

    int n_checks;
    int n_errors;

    logic [c_W-1:0] xf[$];
    logic [c_W-1:0] exp_q[$];
    int             got_done;
    int             stable_bad;
    int             busy_low;

    dds_sweep_gen #(
        .G_DOUT_WIDTH (c_W),
        .G_CNT_WIDTH  (c_C)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .start      (start),
        .mode       (mode),
        .f_start    (f_start),
        .f_step     (f_step),
        .num_steps  (num_steps),
        .dwell      (dwell),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [c_W-1:0] fs, input logic [c_W-1:0] st,
                           input logic [c_C-1:0] ns, input logic [c_C-1:0] dw);
        mode = m; f_start = fs; f_step = st; num_steps = ns; dwell = dw;
    endtask

    // Pulses start for one cycle; returns at the negedge of cycle 1.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Collects transfers at negedges until max_xfer transfers, a done pulse, or budget.
    task automatic collect(input int max_xfer, input bit rnd, input bit disturb, input int budget);
        logic           prev_stall;
        logic [c_W-1:0] prev_dout;
        xf.delete();
        got_done = 0; stable_bad = 0; busy_low = 0;
        prev_stall = 1'b0; prev_dout = '0;
        for (int c = 0; c < budget; c++) begin
            if (done) got_done = 1;
            if (got_done != 0 || xf.size() >= max_xfer) break;
            if (prev_stall && dout !== prev_dout) stable_bad++;
            if (!busy) busy_low++;
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dout_valid && dout_ready) xf.push_back(dout);
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            if (disturb && xf.size() == 2) begin
                start = 1'b1;
                set_cfg(2'd1, 24'hABCDEF, 24'h000777, 16'd9, 16'd7);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        dout_ready = 1'b1;
    endtask

    task automatic compare_xfers(input string tag);
        check({tag, "_count"}, 32'(xf.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < xf.size(); i++)
            check($sformatf("%s_x%0d", tag, i), 32'(xf[i]), 32'(exp_q[i]));
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset_n = 1'b0; enable = 1'b1; start = 1'b0; dout_ready = 1'b1;
        set_cfg(2'd0, '0, '0, '0, '0);
        #12;
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_dout",  32'(dout),       32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single sweep, ready tied high: exact cycle timing
        set_cfg(2'd0, 24'h000100, 24'h000010, 16'd3, 16'd2);
        exp_q = '{24'h100, 24'h100, 24'h110, 24'h110, 24'h120, 24'h120};
        do_start();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("single_dout%0d", i + 1), 32'(dout), 32'(exp_q[i]));
            check($sformatf("single_valid%0d", i + 1), 32'(dout_valid), 32'd1);
            check($sformatf("single_done%0d", i + 1), 32'(done), 32'd0);
            @(negedge clk);
        end
        check("single_valid7", 32'(dout_valid), 32'd0);
        check("single_done7",  32'(done),       32'd1);
        check("single_busy7",  32'(busy),       32'd0);
        @(negedge clk);
        check("single_done8",  32'(done),       32'd0);

        // Backpressure: same sequence, stable output while stalled
        do_start();
        collect(100, 1'b1, 1'b0, 400);
        compare_xfers("bp");
        check("bp_stable", 32'(stable_bad), 32'd0);
        check("bp_done",   32'(got_done),   32'd1);

        // Start and config changes during RUN are ignored
        do_start();
        collect(100, 1'b0, 1'b1, 100);
        compare_xfers("ign");
        check("ign_done", 32'(got_done), 32'd1);
        @(negedge clk);
        check("ign_idle", 32'(dout_valid), 32'd0);

        // Triangle
        set_cfg(2'd2, 24'h0, 24'h1, 16'd3, 16'd1);
        exp_q = '{24'd0, 24'd1, 24'd2, 24'd1, 24'd0, 24'd1, 24'd2, 24'd1};
        do_start();
        collect(8, 1'b0, 1'b0, 100);
        compare_xfers("tri");
        check("tri_nodone", 32'(got_done), 32'd0);
        check("tri_busy",   32'(busy_low), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        check("dis_valid", 32'(dout_valid), 32'd0);
        check("dis_busy",  32'(busy),       32'd0);
        check("dis_dout",  32'(dout),       32'd0);
        enable = 1'b1;

        // Sawtooth with two's-complement wrap
        set_cfg(2'd1, 24'h7FFFFE, 24'h1, 16'd4, 16'd1);
        exp_q = '{24'h7FFFFE, 24'h7FFFFF, 24'h800000, 24'h800001,
                  24'h7FFFFE, 24'h7FFFFF, 24'h800000, 24'h800001};
        do_start();
        collect(8, 1'b1, 1'b0, 200);
        compare_xfers("saw");
        check("saw_nodone", 32'(got_done), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;

        // Triangle with a single level holds f_start
        set_cfg(2'd2, 24'h000345, 24'h10, 16'd1, 16'd1);
        exp_q = '{24'h345, 24'h345, 24'h345, 24'h345};
        do_start();
        collect(4, 1'b0, 1'b0, 50);
        compare_xfers("tri1");
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;

        // Zero counts behave as one
        set_cfg(2'd0, 24'h00ABCD, 24'h10, 16'd0, 16'd0);
        exp_q = '{24'h00ABCD};
        do_start();
        collect(100, 1'b0, 1'b0, 50);
        compare_xfers("zero");
        check("zero_done", 32'(got_done), 32'd1);

        // Asynchronous reset mid-sweep
        set_cfg(2'd0, 24'h000200, 24'h1, 16'd10, 16'd5);
        do_start();
        repeat (3) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_busy",  32'(busy),       32'd0);
        check("abort_dout",  32'(dout),       32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        got_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) got_done = 1;
        end
        check("abort_nodone", 32'(got_done),   32'd0);
        check("abort_idle",   32'(dout_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
